// File: rtl/seqsum_pkg.sv
// Shared types and default sizes for the round-robin sequential-sum scheduler.
package seqsum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 32;
    localparam int LW_DEF   = 8;

endpackage

// File: rtl/seqsum_core.sv
// Registered accumulator: clears on clr, otherwise adds a+b each enabled cycle (modulo 2^DW).
module seqsum_core
    import seqsum_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_y
);

    logic [DW-1:0] r_y;

    // Accumulator register; clear has priority over enable, carries out of DW bits are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_y <= '0;
        end else if (i_clr) begin
            r_y <= '0;
        end else if (i_en) begin
            r_y <= r_y + i_a + i_b;
        end else begin
            r_y <= r_y;
        end
    end

    assign o_y = r_y;

endmodule

// File: rtl/seqsum_arb.sv
// Round-robin scheduler granting one job at a time to the shared seqsum_core accumulator.
module seqsum_arb
    import seqsum_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int LW   = LW_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ*DW-1:0] i_req_a,
    input  logic [NREQ*DW-1:0] i_req_b,
    input  logic [NREQ*LW-1:0] i_req_len,
    output logic [NREQ-1:0]    o_gnt,
    output logic [NREQ-1:0]    o_done,
    output logic [DW-1:0]      o_result,
    output logic               o_busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          r_state;
    logic [IW-1:0]   r_rr;
    logic [IW-1:0]   r_w;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_cnt;
    logic [NREQ-1:0] r_done;
    logic [DW-1:0]   r_result;
    logic            r_busy;

    logic            w_found;
    logic [IW-1:0]   w_win;
    logic [IW:0]     w_idx;
    logic [NREQ-1:0] w_gnt;
    logic [DW-1:0]   w_y;
    logic            w_clr;
    logic            w_en;

    // Round-robin search: first requester at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_rr} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(NREQ)) begin
                w_idx = w_idx - (IW+1)'(NREQ);
            end else begin
                w_idx = w_idx;
            end
            if (!w_found && i_req[w_idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IW-1:0];
            end else begin
                w_found = w_found;
            end
        end
    end

    // Grant is combinational so a request dropped before this cycle can never be accepted.
    always_comb begin
        w_gnt = '0;
        if ((r_state == ST_IDLE) && !i_rst && w_found) begin
            w_gnt = NREQ'(1) << w_win;
        end else begin
            w_gnt = '0;
        end
    end

    assign w_clr = (r_state == ST_CLR);
    assign w_en  = (r_state == ST_RUN) && (r_cnt != '0);

    seqsum_core #(.DW(DW)) u_core (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_clr),
        .i_en  (w_en),
        .i_a   (r_a),
        .i_b   (r_b),
        .o_y   (w_y)
    );

    // Job sequencer: capture on grant, clear, count down len accumulations, report result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_rr     <= '0;
            r_w      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_done   <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= '0;
                    if (w_found) begin
                        r_w     <= w_win;
                        r_a     <= i_req_a[w_win*DW +: DW];
                        r_b     <= i_req_b[w_win*DW +: DW];
                        r_len   <= i_req_len[w_win*LW +: LW];
                        r_rr    <= (w_win == IW'(NREQ-1)) ? '0 : w_win + IW'(1);
                        r_busy  <= 1'b1;
                        r_state <= ST_CLR;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLR: begin
                    r_cnt   <= r_len;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - LW'(1);
                    end else begin
                        r_done   <= NREQ'(1) << r_w;
                        r_result <= w_y;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt    = w_gnt;
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_busy   = r_busy;

endmodule

// File: tb/tb_seqsum_arb.sv
// Self-checking bench for seqsum_arb: per-cycle job-level model plus directed literal checks.
module tb_seqsum_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int LW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] ra  = '0;
    logic [N*DW-1:0] rb  = '0;
    logic [N*LW-1:0] rl  = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [DW-1:0]   result;
    logic            busy;

    always #5 clk = ~clk;

    seqsum_arb #(.NREQ(N), .DW(DW), .LW(LW)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_req_a   (ra),
        .i_req_b   (rb),
        .i_req_len (rl),
        .o_gnt     (gnt),
        .o_done    (done),
        .o_result  (result),
        .o_busy    (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Job-level model: idle flag, rr pointer, scheduled done cycle and result (a+b)*len.
    bit          m_idle = 1'b1;
    int          m_rr   = 0;
    int          m_w    = 0;
    longint      m_done_at = -1;
    logic [31:0] m_res  = '0;
    longint      cyc    = 0;

    int          gnt_q[$];
    longint      gnt_cyc_q[$];
    longint      last_gnt_cyc  = 0;
    longint      last_done_cyc = 0;
    logic [31:0] last_res      = '0;
    int          n_done_ev     = 0;
    int          n_gnt2        = 0;

    function automatic int pick(input logic [N-1:0] rq, input int rr);
        for (int k = 0; k < N; k++) begin
            if (rq[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int          w;
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        logic [31:0] s;
        w  = pick(req, m_rr);
        eg = (!rst && m_idle && w >= 0) ? (N'(1) << w) : '0;
        ed = (!m_idle && cyc == m_done_at) ? (N'(1) << m_w) : '0;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("done", 32'(done), 32'(ed));
        chk("busy", 32'(busy), 32'(!m_idle));
        if (ed != '0) chk("result", result, m_res);
        if (gnt != '0) begin
            for (int k = 0; k < N; k++) if (gnt[k]) gnt_q.push_back(k);
            gnt_cyc_q.push_back(cyc);
            last_gnt_cyc = cyc;
            if (gnt[2]) n_gnt2++;
        end
        if (done != '0) begin
            last_res      = result;
            last_done_cyc = cyc;
            n_done_ev++;
        end
        if (rst) begin
            m_idle = 1'b1;
            m_rr   = 0;
        end else if (eg != '0) begin
            m_idle    = 1'b0;
            m_w       = w;
            m_rr      = (w + 1) % N;
            s         = ra[w*DW +: DW] + rb[w*DW +: DW];
            m_res     = s * 32'(rl[w*LW +: LW]);
            m_done_at = cyc + longint'(rl[w*LW +: LW]) + 3;
        end else if (ed != '0) begin
            m_idle = 1'b1;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int i, input logic [31:0] a, input logic [31:0] b, input logic [7:0] l);
        ra[i*DW +: DW] = a;
        rb[i*DW +: DW] = b;
        rl[i*LW +: LW] = l;
        req[i] = 1'b1;
    endtask

    task automatic wait_gnt(input int i);
        int t;
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            if (gnt[i]) break;
        end
        chk("gnt wait", 32'(t < 100), 32'd1);
        tick();
        req[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int t;
        for (t = 0; t < 400; t++) begin
            @(negedge clk);
            if (done[i]) break;
        end
        chk("done wait", 32'(t < 400), 32'd1);
        tick();
    endtask

    initial begin
        int exp_ord[5];
        int t;
        exp_ord = '{0, 1, 2, 3, 0};
        repeat (3) tick();
        chk("reset result", result, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // all four requesting, len=1: strict rotation 0,1,2,3,0 every len+4 cycles
        gnt_q.delete();
        gnt_cyc_q.delete();
        for (int i = 0; i < N; i++) post(i, 32'(i + 1), 32'd0, 8'd1);
        for (t = 0; t < 200; t++) begin
            @(posedge clk);
            if (gnt_q.size() >= 5) break;
        end
        #1;
        req = '0;
        chk("rr wait", 32'(t < 200), 32'd1);
        if (gnt_q.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr order", 32'(gnt_q[k]), 32'(exp_ord[k]));
            for (int k = 1; k < 5; k++) chk("rr spacing", 32'(gnt_cyc_q[k] - gnt_cyc_q[k-1]), 32'd5);
        end
        wait_done(0);

        post(0, 32'd1, 32'd10, 8'd5);
        wait_gnt(0);
        wait_done(0);
        chk("t1 result", last_res, 32'd55);
        chk("t1 latency", 32'(last_done_cyc - last_gnt_cyc), 32'd8);

        post(0, 32'd7, 32'd9, 8'd0);
        wait_gnt(0);
        wait_done(0);
        chk("t2 result", last_res, 32'd0);
        chk("t2 latency", 32'(last_done_cyc - last_gnt_cyc), 32'd3);

        post(0, 32'hFFFF_FFFF, 32'd2, 8'd3);
        wait_gnt(0);
        wait_done(0);
        chk("t4 wrap", last_res, 32'h0000_0003);

        n_gnt2 = 0;
        post(1, 32'd5, 32'd6, 8'd6);
        wait_gnt(1);
        ra[2*DW +: DW] = 32'd100;
        rl[2*LW +: LW] = 8'd1;
        req[2] = 1'b1;
        tick();
        tick();
        req[2] = 1'b0;
        wait_done(1);
        repeat (4) tick();
        chk("t6 no gnt2", 32'(n_gnt2), 32'd0);
        chk("t6 result", last_res, 32'd66);

        post(3, 32'd1, 32'd1, 8'd20);
        wait_gnt(3);
        repeat (8) tick();
        n_done_ev = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5 busy after rst", 32'(busy), 32'd0);
        repeat (30) tick();
        chk("t5 no done", 32'(n_done_ev), 32'd0);
        post(3, 32'd3, 32'd4, 8'd2);
        wait_gnt(3);
        wait_done(3);
        chk("t5 next result", last_res, 32'd14);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
